// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch master and a data master onto
// one shared variable-latency memory port. One transaction at a time:
// IDLE -> IBUSY/DBUSY -> RESP -> IDLE.
// Optional feature macro: ARB_FAIRNESS_EN (fetch starvation guard).
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch master
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   // data master
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   // shared memory port
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic [31:0] m_rdata,
   input  logic        m_ready,
   // pipeline stalls
   output logic        i_stall,
   output logic        d_stall
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

   state_t      r_state;
   logic        r_m_req;
   logic        r_m_we;
   logic [31:0] r_m_addr;
   logic [31:0] r_m_wdata;
   logic [3:0]  r_m_be;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;
   logic        r_i_ack;
   logic        r_d_ack;

   logic        w_fetch_first;
   logic        w_grant_d;
   logic        w_grant_i;

`ifdef ARB_FAIRNESS_EN
   localparam int CNT_W = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] r_starve_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= SAT_VAL)
         sat_inc = SAT_VAL;
      else
         sat_inc = v + CNT_W'(1);
   endfunction

   // A fetch that has been overtaken STARVE_MAX times wins the next tie
   assign w_fetch_first = i_req & d_req & (r_starve_cnt == SAT_VAL);

   // Count data grants that overtake a waiting fetch; clear once fetch is served or gone
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (r_state == IDLE) begin
         if (w_grant_d && i_req)
            r_starve_cnt <= sat_inc(r_starve_cnt);
         else if (w_grant_i || !i_req)
            r_starve_cnt <= '0;
      end
   end
`else
   // Fairness disabled: data always wins (constant false for any legal STARVE_MAX)
   assign w_fetch_first = (STARVE_MAX < 0);
`endif

   assign w_grant_d = d_req & ~w_fetch_first;
   assign w_grant_i = i_req & ~w_grant_d;

   // Main FSM: captures owner attributes on grant, waits for m_ready, pulses ack in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_be    <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_state   <= DBUSY;
                  r_m_req   <= 1'b1;
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_wdata;
                  r_m_be    <= d_be;
               end else if (w_grant_i) begin
                  r_state   <= IBUSY;
                  r_m_req   <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= i_addr;
                  r_m_wdata <= '0;
                  r_m_be    <= 4'hF;
               end
            end
            IBUSY: begin
               if (m_ready) begin
                  r_i_rdata <= m_rdata;
                  r_m_req   <= 1'b0;
                  r_i_ack   <= 1'b1;
                  r_state   <= RESP;
               end
            end
            DBUSY: begin
               // Stores also latch m_rdata; the consumer ignores it for stores
               if (m_ready) begin
                  r_d_rdata <= m_rdata;
                  r_m_req   <= 1'b0;
                  r_d_ack   <= 1'b1;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_m_req <= 1'b0;
            end
         endcase
      end
   end

   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_be    = r_m_be;
   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;
   assign i_ack   = r_i_ack;
   assign d_ack   = r_d_ack;
   assign i_stall = i_req & ~r_i_ack;
   assign d_stall = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected memory-port
// transactions and expected acks, checked by an independent monitor.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [31:0] m_rdata;
   logic        m_ready;
   logic        i_stall;
   logic        d_stall;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_be(m_be), .m_rdata(m_rdata), .m_ready(m_ready),
      .i_stall(i_stall), .d_stall(d_stall)
   );

   typedef struct packed {
      logic        own;     // 1 = data, 0 = fetch
      logic [31:0] rdata;
   } rsp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mtx_t;

   rsp_t exp_rsp[$];
   mtx_t exp_m[$];
   rsp_t mon_r;
   mtx_t mon_m;
   logic mon_valid;
   logic prev_mreq;

   int vectors;
   int miscompares;
   int lat;
   int age;
   int d_left;
   logic ready_after_rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100)
         mem_word = 32'h0050_0093;
      else
         mem_word = a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic exp_fetch(input logic [31:0] a);
      exp_m.push_back('{we: 1'b0, addr: a, wdata: 32'h0, be: 4'hF});
      exp_rsp.push_back('{own: 1'b0, rdata: mem_word(a)});
   endtask

   task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
      exp_m.push_back('{we: we, addr: a, wdata: wd, be: be});
      exp_rsp.push_back('{own: 1'b1, rdata: mem_word(a)});
   endtask

   // Hold requests until acked; data may be re-issued d_left more times
   task automatic drive_until_done(input int budget);
      int n;
      n = 0;
      while ((i_req || d_req) && n < budget) begin
         @(negedge clk);
         n++;
         if (d_ack) begin
            if (d_left > 0) begin
               d_left--;
               d_addr = d_addr + 32'd4;
            end else begin
               d_req = 1'b0;
            end
         end
         if (i_ack) i_req = 1'b0;
      end
      if (i_req || d_req) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: requests pending after %0d cycles, required completion", budget);
         i_req  = 1'b0;
         d_req  = 1'b0;
         d_left = 0;
      end
   endtask

   // Memory responder: m_ready lat cycles after m_req rises
   initial begin
      age     = -1;
      m_ready = 1'b0;
      m_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (m_req === 1'b1) age = (age < 0) ? 0 : age + 1;
         else age = -1;
         if (ready_after_rst) begin
            ready_after_rst = 1'b0;
            m_ready = 1'b1;
            m_rdata = 32'hBAD0_0001;
         end else if (m_req === 1'b1 && age == lat) begin
            m_ready = 1'b1;
            m_rdata = mem_word(m_addr);
         end else begin
            m_ready = 1'b0;
            m_rdata = 32'h0;
         end
      end
   end

   // Monitor: compares memory-port transactions and acks against the scoreboard
   initial begin
      prev_mreq = 1'b0;
      mon_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (i_ack === 1'b1 || d_ack === 1'b1) begin
            check("ack_exclusive", 32'(i_ack & d_ack), 32'h0);
            check("mreq_in_resp", 32'(m_req), 32'h0);
            if (exp_rsp.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, expected none", i_ack, d_ack);
            end else begin
               mon_r = exp_rsp.pop_front();
               check("ack_owner", 32'(d_ack), 32'(mon_r.own));
               check("ack_rdata", mon_r.own ? d_rdata : i_rdata, mon_r.rdata);
            end
         end
         if (m_req === 1'b1) begin
            if (prev_mreq !== 1'b1) begin
               if (exp_m.size() == 0) begin
                  vectors++;
                  miscompares++;
                  mon_valid = 1'b0;
                  $display("FAIL unexpected_mreq: addr=0x%08h, expected no request", m_addr);
               end else begin
                  mon_m = exp_m.pop_front();
                  mon_valid = 1'b1;
               end
            end
            if (mon_valid) begin
               check("m_we", 32'(m_we), 32'(mon_m.we));
               check("m_addr", m_addr, mon_m.addr);
               check("m_wdata", m_wdata, mon_m.wdata);
               check("m_be", 32'(m_be), 32'(mon_m.be));
            end
         end
         prev_mreq = m_req;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Directed stimulus
   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      lat = 1;
      d_left = 0;
      ready_after_rst = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_i_ack", 32'(i_ack), 32'h0);
      check("rst_d_ack", 32'(d_ack), 32'h0);
      check("rst_m_req", 32'(m_req), 32'h0);
      check("rst_m_we", 32'(m_we), 32'h0);
      check("rst_m_addr", m_addr, 32'h0);
      check("rst_m_wdata", m_wdata, 32'h0);
      check("rst_m_be", 32'(m_be), 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // single fetch, m_ready two cycles after m_req
      lat = 2;
      i_addr = 32'h0000_0100;
      exp_fetch(32'h0000_0100);
      i_req = 1'b1;
      drive_until_done(50);
      check("fetch_rdata", i_rdata, 32'h0050_0093);
      @(negedge clk);
      check("fetch_ack_pulse", 32'(i_ack), 32'h0);

      // simultaneous requests: store first, then fetch
      lat = 1;
      d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
      i_addr = 32'h0000_0104;
      exp_data(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
      exp_fetch(32'h0000_0104);
      d_req = 1'b1;
      i_req = 1'b1;
      drive_until_done(50);
      check("simul_i_rdata", i_rdata, 32'h5A5A_0104);
      check("simul_d_rdata", d_rdata, 32'h5A5A_2000);
      @(negedge clk);

      // partial-byte store with longer latency
      lat = 3;
      d_we = 1'b1; d_addr = 32'h0000_2004; d_wdata = 32'h1234_5678; d_be = 4'h3;
      exp_data(1'b1, 32'h0000_2004, 32'h1234_5678, 4'h3);
      d_req = 1'b1;
      drive_until_done(50);
      check("store_be3_rdata", d_rdata, 32'h5A5A_2004);
      @(negedge clk);

      // stalls: load with m_ready at k=5, fetch raised two cycles in
      lat = 4;
      d_we = 1'b0; d_addr = 32'h0000_4000; d_wdata = 32'h0; d_be = 4'hF;
      i_addr = 32'h0000_4100;
      exp_data(1'b0, 32'h0000_4000, 32'h0, 4'hF);
      exp_fetch(32'h0000_4100);
      for (int c = 0; c < 15; c++) begin
         if (c == 0) d_req = 1'b1;
         if (c == 2) i_req = 1'b1;
         #1;
         check("d_stall", 32'(d_stall), 32'(c < 6));
         check("i_stall", 32'(i_stall), 32'(c >= 2 && c < 13));
         check("d_ack_time", 32'(d_ack), 32'(c == 6));
         check("i_ack_time", 32'(i_ack), 32'(c == 13));
         if (c == 6) d_req = 1'b0;
         if (c == 13) i_req = 1'b0;
         @(negedge clk);
      end

      // starvation: data re-asserted for 20 transactions while fetch waits
      lat = 1;
      d_we = 1'b0; d_addr = 32'h0000_3000; d_wdata = 32'h0; d_be = 4'hF;
      i_addr = 32'h0000_0180;
`ifdef ARB_FAIRNESS_EN
      for (int n = 0; n < 20; n++) begin
         if (n == 4) exp_fetch(32'h0000_0180);
         exp_data(1'b0, 32'h0000_3000 + 32'(4 * n), 32'h0, 4'hF);
      end
`else
      for (int n = 0; n < 20; n++)
         exp_data(1'b0, 32'h0000_3000 + 32'(4 * n), 32'h0, 4'hF);
      exp_fetch(32'h0000_0180);
`endif
      d_left = 19;
      d_req = 1'b1;
      i_req = 1'b1;
      drive_until_done(600);
      @(negedge clk);

      // reset in the middle of a load: no ack, late m_ready ignored
      lat = 10;
      d_we = 1'b0; d_addr = 32'h0000_5000; d_wdata = 32'h0; d_be = 4'hF;
      exp_m.push_back('{we: 1'b0, addr: 32'h0000_5000, wdata: 32'h0, be: 4'hF});
      d_req = 1'b1;
      @(negedge clk);
      check("midop_m_req_busy", 32'(m_req), 32'h1);
      rst = 1'b1;
      d_req = 1'b0;
      ready_after_rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midop_m_req_after_rst", 32'(m_req), 32'h0);
      check("midop_d_ack_after_rst", 32'(d_ack), 32'h0);
      check("midop_d_rdata_after_rst", d_rdata, 32'h0);
      check("midop_i_rdata_after_rst", i_rdata, 32'h0);
      check("midop_m_addr_after_rst", m_addr, 32'h0);
      check("midop_m_be_after_rst", 32'(m_be), 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("midop_no_d_ack", 32'(d_ack), 32'h0);
         check("midop_no_m_req", 32'(m_req), 32'h0);
      end

      // normal fetch after reset recovery
      lat = 1;
      i_addr = 32'h0000_0200;
      exp_fetch(32'h0000_0200);
      i_req = 1'b1;
      drive_until_done(50);
      check("post_rst_fetch_rdata", i_rdata, 32'h5A5A_0200);

      repeat (4) @(negedge clk);
      check("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
      check("exp_m_drained", 32'(exp_m.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
